// File: rtl/baud_tick_gen.sv
// Fractional baud-rate tick generator: oversample, mid-bit and end-of-bit ticks plus a bit-rate
// square wave, with a shadowed divisor that only takes effect on a bit boundary.
module baud_tick_gen #(
  parameter int unsigned DIV_WIDTH    = 16,
  parameter int unsigned FRAC_WIDTH   = 4,
  parameter int unsigned OVERSAMPLE   = 16,  // must be >= 2 and even
  parameter int unsigned DEFAULT_DIV  = 52,
  parameter int unsigned DEFAULT_FRAC = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  resync,
  input  logic [DIV_WIDTH-1:0]  div_int,
  input  logic [FRAC_WIDTH-1:0] div_frac,
  input  logic                  div_load,
  output logic                  div_pending,
  output logic                  os_tick,
  output logic                  mid_tick,
  output logic                  bit_tick,
  output logic                  baud_out
);

  localparam int unsigned OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  typedef logic [OS_W-1:0] os_cnt_t;
  localparam os_cnt_t OS_MID  = os_cnt_t'(OVERSAMPLE / 2 - 1);
  localparam os_cnt_t OS_LAST = os_cnt_t'(OVERSAMPLE - 1);

  logic [DIV_WIDTH-1:0]  active_int_q,  active_int_d;
  logic [FRAC_WIDTH-1:0] active_frac_q, active_frac_d;
  logic [DIV_WIDTH-1:0]  shadow_int_q,  shadow_int_d;
  logic [FRAC_WIDTH-1:0] shadow_frac_q, shadow_frac_d;
  logic                  pending_q,     pending_d;
  logic [DIV_WIDTH-1:0]  cnt_q,         cnt_d;
  logic [FRAC_WIDTH-1:0] acc_q,         acc_d;
  logic                  carry_q,       carry_d;
  os_cnt_t               os_cnt_q,      os_cnt_d;
  logic                  os_tick_q,     os_tick_d;
  logic                  mid_tick_q,    mid_tick_d;
  logic                  bit_tick_q,    bit_tick_d;
  logic                  baud_q,        baud_d;

  logic [DIV_WIDTH:0]    eff_div;
  logic [DIV_WIDTH:0]    period_m1;
  logic [FRAC_WIDTH:0]   frac_sum;
  logic                  os_hit;
  logic                  apply;

  // One extra bit keeps an all-ones divisor plus carry from wrapping.
  always_comb begin
    eff_div   = (active_int_q == '0) ? (DIV_WIDTH+1)'(1) : {1'b0, active_int_q};
    period_m1 = eff_div + (DIV_WIDTH+1)'(carry_q) - (DIV_WIDTH+1)'(1);
    // ">=" rather than "==" so a divisor shrunk while idle cannot strand cnt above the new period.
    os_hit    = ({1'b0, cnt_q} >= period_m1);
    frac_sum  = {1'b0, acc_q} + {1'b0, active_frac_q};
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    active_int_d  = active_int_q;
    active_frac_d = active_frac_q;
    shadow_int_d  = shadow_int_q;
    shadow_frac_d = shadow_frac_q;
    pending_d     = pending_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    carry_d       = carry_q;
    os_cnt_d      = os_cnt_q;
    baud_d        = baud_q;
    os_tick_d     = 1'b0;
    mid_tick_d    = 1'b0;
    bit_tick_d    = 1'b0;

    if (resync) begin
      cnt_d    = '0;
      os_cnt_d = '0;
      acc_d    = '0;
      carry_d  = 1'b0;
      baud_d   = 1'b0;
    end else if (enable) begin
      if (os_hit) begin
        cnt_d              = '0;
        os_tick_d          = 1'b1;
        {carry_d, acc_d}   = frac_sum;
        os_cnt_d           = (os_cnt_q == OS_LAST) ? '0 : os_cnt_t'(os_cnt_q + 1'b1);
        if (os_cnt_q == OS_MID) begin
          mid_tick_d = 1'b1;
          baud_d     = 1'b1;
        end
        if (os_cnt_q == OS_LAST) begin
          bit_tick_d = 1'b1;
          baud_d     = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // A waiting divisor lands on a bit boundary, or at once while the generator is idle.
    apply = pending_q && (bit_tick_d || !enable);
    if (apply) begin
      active_int_d  = div_load ? div_int  : shadow_int_q;
      active_frac_d = div_load ? div_frac : shadow_frac_q;
      pending_d     = 1'b0;
      acc_d         = '0;
      carry_d       = 1'b0;
    end else if (div_load) begin
      shadow_int_d  = div_int;
      shadow_frac_d = div_frac;
      pending_d     = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_int_q  <= DIV_WIDTH'(DEFAULT_DIV);
      active_frac_q <= FRAC_WIDTH'(DEFAULT_FRAC);
      shadow_int_q  <= DIV_WIDTH'(DEFAULT_DIV);
      shadow_frac_q <= FRAC_WIDTH'(DEFAULT_FRAC);
      pending_q     <= 1'b0;
      cnt_q         <= '0;
      acc_q         <= '0;
      carry_q       <= 1'b0;
      os_cnt_q      <= '0;
      os_tick_q     <= 1'b0;
      mid_tick_q    <= 1'b0;
      bit_tick_q    <= 1'b0;
      baud_q        <= 1'b0;
    end else begin
      active_int_q  <= active_int_d;
      active_frac_q <= active_frac_d;
      shadow_int_q  <= shadow_int_d;
      shadow_frac_q <= shadow_frac_d;
      pending_q     <= pending_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      carry_q       <= carry_d;
      os_cnt_q      <= os_cnt_d;
      os_tick_q     <= os_tick_d;
      mid_tick_q    <= mid_tick_d;
      bit_tick_q    <= bit_tick_d;
      baud_q        <= baud_d;
    end
  end

  assign div_pending = pending_q;
  assign os_tick     = os_tick_q;
  assign mid_tick    = mid_tick_q;
  assign bit_tick    = bit_tick_q;
  assign baud_out    = baud_q;

endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
- Parametrised successor to the square-wave baud divider used by the UART.
- Produces an oversample tick for the RX sampler, a bit tick for the TX shifter, a mid-bit tick for RX sampling, and a 50 %-duty bit-rate square wave for legacy consumers.
- Supports a runtime-programmable integer-plus-fractional divisor, glitch-free divisor updates at bit boundaries, and phase resync from the RX start-bit detector.

Parameters:
DIV_WIDTH, 16, width of the integer divisor (clocks per oversample tick).
FRAC_WIDTH, 4, width of the fractional divisor, in units of 1/2^FRAC_WIDTH clock.
OVERSAMPLE, 16, oversample ticks per bit. Must be ≥2 and even.
DEFAULT_DIV, 52, integer divisor after reset.
DEFAULT_FRAC, 0, fractional divisor after reset.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  count enable; when low, all state holds
resync  in  1  synchronous phase restart pulse
div_int  in  DIV_WIDTH  new integer divisor, sampled on div_load
div_frac  in  FRAC_WIDTH  new fractional divisor, sampled on div_load
div_load  in  1  one-cycle strobe that captures div_int/div_frac into the shadow register
div_pending  out  1  high while a shadow value awaits application
os_tick  out  1  one-cycle pulse at OVERSAMPLE × baud
mid_tick  out  1  one-cycle pulse at mid-bit
bit_tick  out  1  one-cycle pulse at the end of each bit
baud_out  out  1  square wave at bit rate

Behaviour:
- Reset (asynchronous, active-high):
  - active divisor = DEFAULT_DIV/DEFAULT_FRAC.
  - shadow and active registers cleared/loaded as above; cycle counter, oversample counter, fractional accumulator and carry flag = 0.
  - All outputs = 0.
- Effective integer divisor: D = max(active_int, 1). A divisor of 0 behaves as 1.
- Oversample period: P = D + carry. The compare is DIV_WIDTH+1 bits wide, so all-ones + carry does not wrap.
- Each enabled cycle:
  - If cnt == P-1: cnt←0, os_tick←1, and {carry,acc} ← acc + active_frac (a FRAC_WIDTH+1-bit sum).
  - Otherwise cnt←cnt+1 and os_tick←0.
  - Average period = D + frac/2^FRAC_WIDTH clocks.
- Latency: with frac=0, the first os_tick is registered high in the cycle after the D-th enabled edge. os_tick repeats every D cycles.
- Oversample counter (0..OVERSAMPLE-1) advances on each os_tick:
  - On the os_tick that moves it OVERSAMPLE/2-1 → OVERSAMPLE/2: mid_tick pulses and baud_out←1.
  - On the os_tick that wraps it OVERSAMPLE-1 → 0: bit_tick pulses and baud_out←0.
  - All ticks are registered and coincide with the os_tick cycle.
- enable low: counters, accumulator and baud_out hold; os_tick, mid_tick and bit_tick are 0.
- resync (priority over enable and ticking): next edge clears cnt, oversample counter, acc, carry and baud_out. All tick outputs are 0 that cycle. Counting restarts from zero on the following enabled edge.
- Divisor update:
  - div_load copies the inputs to the shadow register and sets div_pending.
  - A repeated div_load while pending overwrites the shadow.
  - The shadow is applied to the active register (and pending clears) at the edge where bit_tick is generated. If enable is low, it is applied at the next edge instead.
  - The application also clears acc/carry, so the next bit starts clean.
  - div_load in the same cycle as an application: the newly presented value is applied directly and pending clears.
  - resync does not cancel a pending update.
- Reset mid-operation: immediate return to reset values; a pending update is discarded.

Test Plan:
- Load div_int=4, frac=0, OVERSAMPLE=16, enable high -> os_tick every 4 cycles; mid_tick 32 cycles after start; bit_tick every 64 cycles; baud_out high 32 cycles, low 32 cycles.
- div_int=3, div_frac=8 (FRAC_WIDTH=4) -> os_tick spacing alternates 3,4; 16 os_ticks span exactly 56 cycles; bit_tick period 56.
- From div=4, assert div_load with div_int=2 at cycle 10 of a bit -> div_pending high until the bit_tick at cycle 64; the next bit lasts 32 cycles; pending low afterwards.
- div=4, pulse resync at cycle 20 of a bit -> all ticks low that cycle; next os_tick 4 cycles after counting resumes; next mid_tick 32 cycles and next bit_tick 64 cycles after restart.
- div_int=0 -> os_tick every cycle, bit_tick every 16 cycles; deassert enable for 7 cycles mid-bit -> no ticks and baud_out frozen, then the bit completes on schedule +7.
- Assert reset mid-bit with an update pending -> outputs immediately 0, div_pending 0; after release, timing follows DEFAULT_DIV=52 (first os_tick 52 cycles after first enabled edge).
